// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_arb_pkg                                                     |
// | Brief    : Shared types and constants for the unified memory-port arbiter. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    // Field layout mirrors the core's memory_io request/response bundles
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        do_read;
        logic [3:0]  do_write;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } memory_io_rsp;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } arb_src_t;

    localparam memory_io_req MEM_REQ_IDLE = '0;
    localparam memory_io_rsp MEM_RSP_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mem_port_arbiter_if                                            |
// | Brief     : Core-side request/response channels and the memory-side port.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    memory_io_req inst_req;
    logic         inst_req_ready;
    memory_io_rsp inst_rsp;
    memory_io_req data_req;
    logic         data_req_ready;
    memory_io_rsp data_rsp;
    memory_io_req mem_req;
    memory_io_rsp mem_rsp;

    // Environment side: requesters plus the memory model
    modport master (
        output inst_req, data_req, mem_rsp,
        input  inst_req_ready, data_req_ready, inst_rsp, data_rsp, mem_req
    );

    // Arbiter side
    modport slave (
        input  inst_req, data_req, mem_rsp,
        output inst_req_ready, data_req_ready, inst_rsp, data_rsp, mem_req
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_tag_fifo                                                    |
// | Brief    : In-order FIFO of request sources for outstanding memory ops.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    input  wire logic     push,
    input  wire logic     pop,
    input  wire arb_src_t src_in,
    output arb_src_t      src_out,
    output logic          full,
    output logic          empty
);
    localparam int PTR_W = $clog2(DEPTH);

    arb_src_t         mem_q [DEPTH];
    arb_src_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign src_out = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Power-of-two depth lets the pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = src_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Brief    : Shares one memory port between fetch and load/store channels;   |
// |            data-priority with anti-starvation, in-order response routing.  |
// |            Optional perf counters under MEM_ARB_PERF_CNT_EN.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int MAX_DATA_STREAK   = 3
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mem_port_arbiter_if.slave   bus,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]         cnt_inst_grant,
    output logic [31:0]         cnt_data_grant,
    output logic [31:0]         cnt_conflict,
`endif
    output logic                err_orphan_rsp
);
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic                grant_inst;
    logic                grant_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rsp_hit;
    arb_src_t            head_src;
    arb_src_t            push_src;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                err_q,    err_d;

    arb_tag_fifo #(
        .DEPTH   (OUTSTANDING_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (grant_inst || grant_data),
        .pop     (rsp_hit),
        .src_in  (push_src),
        .src_out (head_src),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset && !fifo_full) begin
            if (bus.inst_req.valid && bus.data_req.valid) begin
                if (streak_q == STREAK_MAX) grant_inst = 1'b1;
                else                        grant_data = 1'b1;
            end else if (bus.inst_req.valid) begin
                grant_inst = 1'b1;
            end else if (bus.data_req.valid) begin
                grant_data = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_req        = MEM_REQ_IDLE;
        bus.inst_req_ready = grant_inst;
        bus.data_req_ready = grant_data;
        push_src           = grant_data ? SRC_DATA : SRC_INST;
        if (grant_inst)      bus.mem_req = bus.inst_req;
        else if (grant_data) bus.mem_req = bus.data_req;
    end

    assign rsp_hit = bus.mem_rsp.valid && !fifo_empty && !reset;

    always_comb begin
        bus.inst_rsp = MEM_RSP_IDLE;
        bus.data_rsp = MEM_RSP_IDLE;
        if (rsp_hit) begin
            if (head_src == SRC_INST) bus.inst_rsp = bus.mem_rsp;
            else                      bus.data_rsp = bus.mem_rsp;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!bus.inst_req.valid || grant_inst) begin
            streak_d = '0;
        end else if (grant_data && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
        err_d = err_q | (bus.mem_rsp.valid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign err_orphan_rsp = err_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] cnt_inst_q, cnt_inst_d;
    logic [31:0] cnt_data_q, cnt_data_d;
    logic [31:0] cnt_conf_q, cnt_conf_d;

    always_comb begin
        cnt_inst_d = cnt_inst_q + {31'd0, grant_inst};
        cnt_data_d = cnt_data_q + {31'd0, grant_data};
        cnt_conf_d = cnt_conf_q + {31'd0, bus.inst_req.valid && bus.data_req.valid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_inst_q <= '0;
            cnt_data_q <= '0;
            cnt_conf_q <= '0;
        end else begin
            cnt_inst_q <= cnt_inst_d;
            cnt_data_q <= cnt_data_d;
            cnt_conf_q <= cnt_conf_d;
        end
    end

    assign cnt_inst_grant = cnt_inst_q;
    assign cnt_data_grant = cnt_data_q;
    assign cnt_conflict   = cnt_conf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                             |
// | Brief    : Directed self-checking bench for mem_port_arbiter.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic reset;
    logic err_orphan_rsp;
    int   n_chk;
    int   n_pass;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] cnt_inst_grant;
    logic [31:0] cnt_data_grant;
    logic [31:0] cnt_conflict;
`endif

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .OUTSTANDING_DEPTH (4),
        .MAX_DATA_STREAK   (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
`ifdef MEM_ARB_PERF_CNT_EN
        .cnt_inst_grant (cnt_inst_grant),
        .cnt_data_grant (cnt_data_grant),
        .cnt_conflict   (cnt_conflict),
`endif
        .err_orphan_rsp (err_orphan_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic memory_io_req mk_req(input logic [31:0] a, input logic [31:0] d,
                                            input logic rd, input logic [3:0] wr);
        memory_io_req r;
        r.valid = 1'b1; r.addr = a; r.data = d; r.do_read = rd; r.do_write = wr;
        return r;
    endfunction

    function automatic memory_io_rsp mk_rsp(input logic [31:0] a, input logic [31:0] d);
        memory_io_rsp r;
        r.valid = 1'b1; r.addr = a; r.data = d;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.inst_req = MEM_REQ_IDLE;
        bus.data_req = MEM_REQ_IDLE;
        bus.mem_rsp  = MEM_RSP_IDLE;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.inst_req = mk_req(32'h0, 32'h0, 1'b1, 4'h0);
        bus.data_req = mk_req(32'h40, 32'h0, 1'b1, 4'h0);
        bus.mem_rsp  = mk_rsp(32'h0, 32'h1234);
        #1;
        n_chk++; if (bus.inst_req_ready !== 1'b0) $display("FAIL reset_inst_ready got %b want 0", bus.inst_req_ready); else n_pass++;
        n_chk++; if (bus.data_req_ready !== 1'b0) $display("FAIL reset_data_ready got %b want 0", bus.data_req_ready); else n_pass++;
        n_chk++; if (bus.mem_req.valid !== 1'b0) $display("FAIL reset_mem_valid got %b want 0", bus.mem_req.valid); else n_pass++;
        n_chk++; if ((bus.inst_rsp.valid | bus.data_rsp.valid) !== 1'b0)
            $display("FAIL reset_rsp_valid got %b/%b want 0/0", bus.inst_rsp.valid, bus.data_rsp.valid); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        n_chk++; if (err_orphan_rsp !== 1'b0) $display("FAIL reset_err got %b want 0", err_orphan_rsp); else n_pass++;
        n_chk++; if (bus.mem_req !== MEM_REQ_IDLE) $display("FAIL idle_mem_req got %h want 0", bus.mem_req); else n_pass++;
        @(negedge clk);
    endtask

    // Memory answers each request two cycles after it is issued
    task automatic test_inst_stream();
        for (int c = 0; c < 5; c++) begin
            bus.inst_req = (c < 3) ? mk_req(32'(4*c), 32'h0, 1'b1, 4'h0) : MEM_REQ_IDLE;
            bus.mem_rsp  = (c >= 2) ? mk_rsp(32'(4*(c-2)), 32'hA0 + 32'(4*(c-2))) : MEM_RSP_IDLE;
            #1;
            if (c < 3) begin
                n_chk++; if (bus.inst_req_ready !== 1'b1) $display("FAIL stream_ready c%0d got %b want 1", c, bus.inst_req_ready); else n_pass++;
                n_chk++; if (bus.mem_req.addr !== 32'(4*c)) $display("FAIL stream_addr c%0d got %h want %h", c, bus.mem_req.addr, 32'(4*c)); else n_pass++;
            end
            if (c >= 2) begin
                n_chk++; if (bus.inst_rsp.valid !== 1'b1 || bus.inst_rsp.data !== 32'hA0 + 32'(4*(c-2)))
                    $display("FAIL stream_rsp c%0d got %b/%h want 1/%h", c, bus.inst_rsp.valid, bus.inst_rsp.data, 32'hA0 + 32'(4*(c-2)));
                else n_pass++;
                n_chk++; if (bus.data_rsp.valid !== 1'b0) $display("FAIL stream_data_rsp c%0d got %b want 0", c, bus.data_rsp.valid); else n_pass++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // Expected data-grant sequence D,D,D,I,D,D (bit c = cycle c)
    task automatic test_streak();
        logic [5:0] exp_d;
        exp_d = 6'b110111;
        for (int c = 0; c < 7; c++) begin
            bus.inst_req = (c < 6) ? mk_req(32'h300, 32'h0, 1'b1, 4'h0) : MEM_REQ_IDLE;
            bus.data_req = (c < 6) ? mk_req(32'h400 + 32'(c), 32'h0, 1'b1, 4'h0) : MEM_REQ_IDLE;
            bus.mem_rsp  = (c >= 1) ? mk_rsp(32'h0, 32'(c)) : MEM_RSP_IDLE;
            #1;
            if (c < 6) begin
                n_chk++; if (bus.data_req_ready !== exp_d[c] || bus.inst_req_ready !== !exp_d[c])
                    $display("FAIL streak_grant c%0d got d%b/i%b want d%b/i%b", c, bus.data_req_ready, bus.inst_req_ready, exp_d[c], !exp_d[c]);
                else n_pass++;
            end
            if (c >= 1) begin
                n_chk++; if (bus.data_rsp.valid !== exp_d[c-1] || bus.inst_rsp.valid !== !exp_d[c-1])
                    $display("FAIL streak_route c%0d got d%b/i%b want d%b/i%b", c, bus.data_rsp.valid, bus.inst_rsp.valid, exp_d[c-1], !exp_d[c-1]);
                else n_pass++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_store_load();
        bus.data_req = mk_req(32'h100, 32'hDEADBEEF, 1'b0, 4'b1111);
        #1;
        n_chk++; if (bus.mem_req !== mk_req(32'h100, 32'hDEADBEEF, 1'b0, 4'b1111))
            $display("FAIL store_mem_req got %h want %h", bus.mem_req, mk_req(32'h100, 32'hDEADBEEF, 1'b0, 4'b1111)); else n_pass++;
        @(negedge clk);
        bus.data_req = mk_req(32'h100, 32'h0, 1'b1, 4'b0000);
        bus.mem_rsp  = mk_rsp(32'h100, 32'h0);
        #1;
        n_chk++; if (bus.mem_req.do_read !== 1'b1 || bus.mem_req.do_write !== 4'b0000)
            $display("FAIL load_mem_req got rd%b/wr%h want rd1/wr0", bus.mem_req.do_read, bus.mem_req.do_write); else n_pass++;
        n_chk++; if (bus.data_rsp.valid !== 1'b1 || bus.inst_rsp.valid !== 1'b0)
            $display("FAIL store_rsp_route got d%b/i%b want d1/i0", bus.data_rsp.valid, bus.inst_rsp.valid); else n_pass++;
        @(negedge clk);
        bus.data_req = MEM_REQ_IDLE;
        bus.mem_rsp  = mk_rsp(32'h100, 32'hDEADBEEF);
        #1;
        n_chk++; if (bus.data_rsp.valid !== 1'b1 || bus.data_rsp.data !== 32'hDEADBEEF)
            $display("FAIL load_rsp got %b/%h want 1/deadbeef", bus.data_rsp.valid, bus.data_rsp.data); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_full();
        for (int c = 0; c < 4; c++) begin
            bus.inst_req = mk_req(32'(4*c), 32'h0, 1'b1, 4'h0);
            #1;
            n_chk++; if (bus.inst_req_ready !== 1'b1) $display("FAIL full_fill c%0d got %b want 1", c, bus.inst_req_ready); else n_pass++;
            @(negedge clk);
        end
        bus.inst_req = mk_req(32'h10, 32'h0, 1'b1, 4'h0);
        #1;
        n_chk++; if (bus.inst_req_ready !== 1'b0 || bus.mem_req.valid !== 1'b0)
            $display("FAIL full_block got r%b/v%b want 0/0", bus.inst_req_ready, bus.mem_req.valid); else n_pass++;
        @(negedge clk);
        bus.mem_rsp = mk_rsp(32'h0, 32'h50);
        #1;
        n_chk++; if (bus.inst_req_ready !== 1'b0) $display("FAIL full_pop_no_regrant got %b want 0", bus.inst_req_ready); else n_pass++;
        n_chk++; if (bus.inst_rsp.valid !== 1'b1) $display("FAIL full_pop_rsp got %b want 1", bus.inst_rsp.valid); else n_pass++;
        @(negedge clk);
        bus.mem_rsp = MEM_RSP_IDLE;
        #1;
        n_chk++; if (bus.inst_req_ready !== 1'b1 || bus.mem_req.addr !== 32'h10)
            $display("FAIL full_regrant got r%b/a%h want 1/10", bus.inst_req_ready, bus.mem_req.addr); else n_pass++;
        @(negedge clk);
        bus.inst_req = MEM_REQ_IDLE;
        for (int c = 0; c < 4; c++) begin
            bus.mem_rsp = mk_rsp(32'h0, 32'(c));
            #1;
            n_chk++; if (bus.inst_rsp.valid !== 1'b1) $display("FAIL full_drain c%0d got %b want 1", c, bus.inst_rsp.valid); else n_pass++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_orphan();
        bus.mem_rsp = mk_rsp(32'h0, 32'hBAD);
        #1;
        n_chk++; if ((bus.inst_rsp.valid | bus.data_rsp.valid) !== 1'b0)
            $display("FAIL orphan_drop got i%b/d%b want 0/0", bus.inst_rsp.valid, bus.data_rsp.valid); else n_pass++;
        @(negedge clk);
        bus.mem_rsp = MEM_RSP_IDLE;
        #1;
        n_chk++; if (err_orphan_rsp !== 1'b1) $display("FAIL orphan_flag got %b want 1", err_orphan_rsp); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (err_orphan_rsp !== 1'b1) $display("FAIL orphan_sticky got %b want 1", err_orphan_rsp); else n_pass++;
        pulse_reset();
        #1;
        n_chk++; if (err_orphan_rsp !== 1'b0) $display("FAIL orphan_clear got %b want 0", err_orphan_rsp); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            bus.inst_req = mk_req(32'h500 + 32'(4*c), 32'h0, 1'b1, 4'h0);
            #1;
            n_chk++; if (bus.inst_req_ready !== 1'b1) $display("FAIL mid_issue c%0d got %b want 1", c, bus.inst_req_ready); else n_pass++;
            @(negedge clk);
        end
        pulse_reset();
        for (int c = 0; c < 2; c++) begin
            bus.mem_rsp = mk_rsp(32'h500 + 32'(4*c), 32'h77);
            #1;
            n_chk++; if ((bus.inst_rsp.valid | bus.data_rsp.valid) !== 1'b0)
                $display("FAIL mid_late_rsp c%0d got i%b/d%b want 0/0", c, bus.inst_rsp.valid, bus.data_rsp.valid); else n_pass++;
            @(negedge clk);
        end
        bus.mem_rsp = MEM_RSP_IDLE;
        #1;
        n_chk++; if (err_orphan_rsp !== 1'b1) $display("FAIL mid_orphan_flag got %b want 1", err_orphan_rsp); else n_pass++;
        @(negedge clk);
        pulse_reset();
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf();
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            bus.inst_req = (c < 6) ? mk_req(32'h600, 32'h0, 1'b1, 4'h0) : MEM_REQ_IDLE;
            bus.data_req = (c < 4) ? mk_req(32'h700, 32'h0, 1'b1, 4'h0) : MEM_REQ_IDLE;
            bus.mem_rsp  = (c >= 1 && c < 7) ? mk_rsp(32'h0, 32'h0) : MEM_RSP_IDLE;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        n_chk++; if (cnt_conflict !== 32'd4) $display("FAIL perf_conflict got %0d want 4", cnt_conflict); else n_pass++;
        n_chk++; if (cnt_inst_grant + cnt_data_grant !== 32'd6)
            $display("FAIL perf_sum got %0d want 6", cnt_inst_grant + cnt_data_grant); else n_pass++;
        n_chk++; if (cnt_data_grant !== 32'd3) $display("FAIL perf_data got %0d want 3", cnt_data_grant); else n_pass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle_inputs();
        test_reset();
        test_inst_stream();
        test_streak();
        test_store_load();
        test_full();
        test_orphan();
        test_reset_mid();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
